// File: rtl/mem_initiator.sv
// Burst command initiator for a simple synchronous memory: fills write bursts,
// issues one read per beat and returns each read word (or an error) as a response.
module mem_initiator #(
  parameter int WIDTH = 8,
  parameter int AW    = 3,
  parameter int DEPTH = 7
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [2:0]       cmd_len,
  input  logic [WIDTH-1:0] cmd_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             write,
  output logic             read,
  output logic [AW-1:0]    addr_w,
  output logic [AW-1:0]    addr_r,
  output logic [WIDTH-1:0] datain,
  input  logic [WIDTH-1:0] dataout
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    READ   = 3'd2,
    RDWAIT = 3'd3,
    RESP   = 3'd4
  } state_t;

  localparam logic [AW:0]   DEPTH_X   = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t        state_r;
  logic [AW-1:0] cur_addr_r;
  logic [2:0]    beats_r;
  logic          addr_bad_s;
  logic [AW-1:0] addr_next_s;

  // Address sequencing wraps inside the valid window so a burst never leaves it.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    logic [AW-1:0] n;
    if (a == LAST_ADDR) begin
      n = {AW{1'b0}};
    end else begin
      n = a + AW'(1'b1);
    end
    return n;
  endfunction

  assign addr_bad_s  = ({1'b0, cmd_addr} >= DEPTH_X);
  assign addr_next_s = next_addr(cur_addr_r);

  // Burst FSM; every output is a register updated together with the state.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cur_addr_r <= {AW{1'b0}};
      beats_r    <= 3'd0;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_data   <= {WIDTH{1'b0}};
      write      <= 1'b0;
      read       <= 1'b0;
      addr_w     <= {AW{1'b0}};
      addr_r     <= {AW{1'b0}};
      datain     <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready  <= 1'b0;
            cur_addr_r <= cmd_addr;
            beats_r    <= cmd_len;
            if (addr_bad_s) begin
              // A bad start address yields a single error response and no strobes.
              beats_r   <= 3'd0;
              state_r   <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= {WIDTH{1'b0}};
            end else if (cmd_we) begin
              state_r <= WRITE;
              write   <= 1'b1;
              addr_w  <= cmd_addr;
              datain  <= cmd_wdata;
            end else begin
              state_r <= READ;
              read    <= 1'b1;
              addr_r  <= cmd_addr;
            end
          end else begin
            state_r <= IDLE;
          end
        end

        WRITE: begin
          if (beats_r == 3'd0) begin
            write     <= 1'b0;
            state_r   <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= {WIDTH{1'b0}};
          end else begin
            beats_r    <= beats_r - 3'd1;
            cur_addr_r <= addr_next_s;
            addr_w     <= addr_next_s;
          end
        end

        READ: begin
          read    <= 1'b0;
          state_r <= RDWAIT;
        end

        RDWAIT: begin
          rsp_data  <= dataout;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state_r   <= RESP;
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            // Only read bursts leave beats pending here; writes and errors finish.
            if (beats_r != 3'd0) begin
              beats_r    <= beats_r - 3'd1;
              cur_addr_r <= addr_next_s;
              addr_r     <= addr_next_s;
              read       <= 1'b1;
              state_r    <= READ;
            end else begin
              cmd_ready <= 1'b1;
              state_r   <= IDLE;
            end
          end else begin
            state_r <= RESP;
          end
        end

        default: begin
          state_r   <= IDLE;
          cmd_ready <= 1'b0;
          rsp_valid <= 1'b0;
          write     <= 1'b0;
          read      <= 1'b0;
        end
      endcase
    end
  end

endmodule
